fetch_queue: RTL

Parametrised instruction-fetch unit with a decoupled instruction queue. Keeps one memory fetch outstanding and prefetches ahead into a QUEUE_DEPTH-entry FIFO. Presents the queue head to the decoder with a valid/ready handshake. Honours ROB misbranch flushes, including discarding a fetch already in flight. Sits between the memory controller and the decoder/issue stage; RS/LSB/ROB backpressure arrives as a single `in_issue_ready`.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction fetch unit with a circular prefetch queue.
// Define FETCHQ_JAL_FOLLOW_EN to redirect the fetch pc on JAL instead of waiting for the ROB.
module fetch_queue #(
    parameter int              QUEUE_DEPTH = 8,
    parameter int              ADDR_W      = 32,
    parameter int              INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rdy,
    output logic                           out_mem_ce,
    output logic [ADDR_W-1:0]              out_mem_pc,
    input  logic                           in_mem_ce,
    input  logic [INSTR_W-1:0]             in_mem_instr,
    output logic                           out_valid,
    output logic [INSTR_W-1:0]             out_instr,
    output logic [ADDR_W-1:0]              out_pc,
    input  logic                           in_issue_ready,
    input  logic                           in_rob_misbranch,
    input  logic [ADDR_W-1:0]              in_rob_newpc,
    output logic [$clog2(QUEUE_DEPTH):0]   out_queue_count
);
    localparam int PW = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, DISCARD} state_t;

    state_t              state, state_nx;
    logic [INSTR_W-1:0]  instr_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0]   pc_q [QUEUE_DEPTH];
    logic [PW-1:0]       head, tail;
    logic [PW:0]         count;
    logic [ADDR_W-1:0]   pc, pc_step;
    logic                push, pop, issue, flush, full;

    assign full            = count == (PW+1)'(QUEUE_DEPTH);
    assign flush           = rdy && in_rob_misbranch;
    assign out_valid       = count != '0;
    assign out_instr       = instr_q[head];
    assign out_pc          = pc_q[head];
    assign out_queue_count = count;

`ifdef FETCHQ_JAL_FOLLOW_EN
    logic [20:0] jal_imm;
    assign jal_imm = {in_mem_instr[31], in_mem_instr[19:12], in_mem_instr[20], in_mem_instr[30:21], 1'b0};
    assign pc_step = (in_mem_instr[6:0] == 7'b1101111) ? pc + ADDR_W'($signed(jal_imm)) : pc + ADDR_W'(4);
`else
    assign pc_step = pc + ADDR_W'(4);
`endif

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        pop      = 1'b0;
        issue    = 1'b0;
        if (flush) begin
            // a response still owed by memory must be swallowed after the flush
            state_nx = (state != IDLE && !in_mem_ce) ? DISCARD : IDLE;
        end else if (rdy) begin
            pop = out_valid && in_issue_ready;
            case (state)
                IDLE:     if (!full) begin issue = 1'b1; state_nx = WAIT_MEM; end
                WAIT_MEM: if (in_mem_ce) begin push = 1'b1; state_nx = IDLE; end
                DISCARD:  if (in_mem_ce) state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            out_mem_ce <= 1'b0;
            out_mem_pc <= '0;
        end else begin
            out_mem_ce <= issue;
            if (issue) out_mem_pc <= pc;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                pc    <= in_rob_newpc;
            end else begin
                if (push) begin
                    tail <= tail + PW'(1);
                    pc   <= pc_step;
                end
                if (pop) head <= head + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[tail] <= in_mem_instr;
            pc_q[tail]    <= pc;
        end
    end
endmodule
